// File: rtl/alu_op_pkg.sv
// ALU operation encoding shared by the
// datapath and the multicycle controller.
package alu_op_pkg;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_SLL,
    ALU_SLT,
    ALU_SLTU,
    ALU_XOR,
    ALU_SRL,
    ALU_SRA,
    ALU_OR,
    ALU_AND
  } alu_op_t;

endpackage

// File: rtl/ctrl_pkg.sv
// Controller states, instruction classes
// and opcode constants.
package ctrl_pkg;

  import alu_op_pkg::*;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB,
    ERR
  } ctrl_state_t;

  typedef enum logic [2:0] {
    CL_NONE,
    CL_LOAD,
    CL_STORE,
    CL_BRANCH,
    CL_RTYPE,
    CL_ITYPE
  } instr_class_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;

  localparam logic [6:0] F7_ZERO = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  function automatic alu_op_t f3_op(
    input logic [2:0] f3,
    input logic       alt
  );
    alu_op_t op;
    op = ALU_ADD;
    unique case (f3)
      3'b000: op = alt ? ALU_SUB : ALU_ADD;
      3'b001: op = ALU_SLL;
      3'b010: op = ALU_SLT;
      3'b011: op = ALU_SLTU;
      3'b100: op = ALU_XOR;
      3'b101: op = alt ? ALU_SRA : ALU_SRL;
      3'b110: op = ALU_OR;
      3'b111: op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational opcode/funct decoder:
// instruction class, ALU op, legality.
module instr_decoder
  import ctrl_pkg::*;
  import alu_op_pkg::*;
(
  input  logic [6:0]   opcode,
  input  logic [2:0]   funct3,
  input  logic [6:0]   funct7,
  output instr_class_t cls,
  output alu_op_t      aluop,
  output logic         legal
);

  logic is_ld;
  logic is_st;
  logic is_br;
  logic is_r;
  logic is_i;
  logic alt;
  logic f7z;
  logic sh;

  assign is_ld = opcode == OP_LOAD;
  assign is_st = opcode == OP_STORE;
  assign is_br = opcode == OP_BRANCH;
  assign is_r  = opcode == OP_RTYPE;
  assign is_i  = opcode == OP_ITYPE;
  assign alt   = funct7 == F7_ALT;
  assign f7z   = funct7 == F7_ZERO;
  assign sh    = funct3 == 3'b001
              || funct3 == 3'b101;

  always_comb begin
    cls   = CL_NONE;
    aluop = ALU_ADD;
    legal = 1'b0;
    unique case (1'b1)
      is_ld: begin
        cls   = CL_LOAD;
        legal = 1'b1;
      end
      is_st: begin
        cls   = CL_STORE;
        legal = 1'b1;
      end
      is_br: begin
        cls   = CL_BRANCH;
        aluop = ALU_SUB;
        legal = 1'b1;
      end
      is_r: begin
        cls   = CL_RTYPE;
        aluop = f3_op(funct3, alt);
        legal = f7z
             || (alt && (funct3 == 3'b000
                      || funct3 == 3'b101));
      end
      is_i: begin
        // funct7 only means something for shifts
        cls   = CL_ITYPE;
        aluop = f3_op(funct3,
                      alt && funct3 == 3'b101);
        legal = !sh || f7z
             || (alt && funct3 == 3'b101);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V control FSM with
// bounded memory wait and sticky error.
module multicycle_controller
  import ctrl_pkg::*;
  import alu_op_pkg::*;
#(
  parameter int WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        iord,
  output logic        ir_we,
  output logic        pc_we,
  output logic        pc_src,
  output logic        ALUSrc,
  output alu_op_t     ALUOp,
  output logic        MemtoReg,
  output logic        RegWrite,
  output logic        illegal,
  output ctrl_state_t state_o
);

  localparam int CW = $clog2(WAIT_MAX + 1);

  ctrl_state_t  state_q;
  ctrl_state_t  state_d;
  instr_class_t cls_q;
  alu_op_t      op_q;
  logic [2:0]   f3_q;
  logic [CW-1:0] cnt_q;

  instr_class_t dec_cls;
  alu_op_t      dec_op;
  logic         dec_legal;
  logic         timeout;

  instr_decoder u_dec (
    .opcode (opcode),
    .funct3 (funct3),
    .funct7 (funct7),
    .cls    (dec_cls),
    .aluop  (dec_op),
    .legal  (dec_legal)
  );

  assign timeout = cnt_q == CW'(WAIT_MAX)
                && !mem_ready;
  assign state_o = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      cls_q   <= CL_NONE;
      op_q    <= ALU_ADD;
      f3_q    <= 3'b000;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == DECODE) begin
        cls_q <= dec_cls;
        op_q  <= dec_op;
        f3_q  <= funct3;
      end
      if (state_d != state_q)
        cnt_q <= '0;
      else if (mem_req && !mem_ready)
        cnt_q <= cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    iord     = 1'b0;
    ir_we    = 1'b0;
    pc_we    = 1'b0;
    pc_src   = 1'b0;
    ALUSrc   = 1'b0;
    ALUOp    = ALU_ADD;
    MemtoReg = 1'b0;
    RegWrite = 1'b0;
    illegal  = 1'b0;
    // outputs are forced quiet while reset is held
    if (rst_n) begin
      unique case (state_q)
        FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_we   = 1'b1;
            pc_we   = 1'b1;
            state_d = DECODE;
          end else if (timeout) begin
            state_d = ERR;
          end
        end
        DECODE: begin
          state_d = dec_legal ? EXEC : ERR;
        end
        EXEC: begin
          ALUOp  = op_q;
          ALUSrc = cls_q inside
                   {CL_LOAD, CL_STORE, CL_ITYPE};
          unique case (cls_q)
            CL_BRANCH: begin
              state_d = FETCH;
              if (f3_q == 3'b000) begin
                pc_src = 1'b1;
                pc_we  = zero;
              end else if (f3_q == 3'b001) begin
                pc_src = 1'b1;
                pc_we  = !zero;
              end else begin
                state_d = ERR;
              end
            end
            CL_LOAD, CL_STORE: state_d = MEM;
            CL_RTYPE, CL_ITYPE: state_d = WB;
            default: state_d = ERR;
          endcase
        end
        MEM: begin
          mem_req = 1'b1;
          iord    = 1'b1;
          mem_we  = cls_q == CL_STORE;
          if (mem_ready)
            state_d = (cls_q == CL_STORE)
                    ? FETCH : WB;
          else if (timeout)
            state_d = ERR;
        end
        WB: begin
          RegWrite = 1'b1;
          MemtoReg = cls_q == CL_LOAD;
          state_d  = FETCH;
        end
        ERR: begin
          illegal = 1'b1;
        end
        default: state_d = ERR;
      endcase
    end
  end

endmodule
